// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Optional macro IF_MISALIGN_CHK_EN: misaligned redirects raise a sticky misalign_o and halt fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        rom_rena_o,
    output logic [31:0] rom_raddr_o,
    input  logic [31:0] rom_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;

`ifdef IF_MISALIGN_CHK_EN
    logic        misalign_q, misalign_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0000_0000;
            id_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    // Every path except a RUN-state stall or fetch leaves a bubble in IF/ID,
    // so the bubble is the default and only those two cases override it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = 1'b0;
        id_pc_d    = 32'h0000_0000;
        id_instr_d = NOP_INSTR;
`ifdef IF_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
`ifdef IF_MISALIGN_CHK_EN
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end
`endif
                end else if (halt_i) begin
                    state_d = HALT;
                end else if (stall_i) begin
                    id_valid_d = id_valid_q;
                    id_pc_d    = id_pc_q;
                    id_instr_d = id_instr_q;
                end else begin
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_q;
                    id_instr_d = rom_rdata_i;
                    pc_d       = pc_q + 32'd4;
                end
            end
            HALT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = RUN;
`ifdef IF_MISALIGN_CHK_EN
                    if (redirect_pc_i[1:0] != 2'b00) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign rom_rena_o  = (state_q == RUN);
    assign rom_raddr_o = pc_q;
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;

`ifdef IF_MISALIGN_CHK_EN
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule
